// File: rtl/cordic_pipe_ctrl_pkg.sv
// Shared types and defaults for the CORDIC pipeline sequencing controller.
package cordic_ctrl_pkg;

  localparam int STAGES_DEF = 32;  // CE-gated datapath stages after the input register
  localparam int TAGW       = 4;   // requester tag width
  localparam int CNTW_DEF   = 6;   // in-flight counter width, 2**CNTW > STAGES+1

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;
  localparam logic [1:0] Q3 = 2'b11;

  // Identity of the operation held in one pipeline slot.
  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [1:0]      quad;
  } slot_t;

endpackage

// File: rtl/cordic_pipe_ctrl_if.sv
// Request/result handshake bundle between a requester and the controller.
interface cordic_pipe_ctrl_if;
  import cordic_ctrl_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_angle;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [TAGW-1:0] out_tag;
  logic [1:0]      out_quad;

  modport master (
    output in_valid, in_angle, in_tag, out_ready,
    input  in_ready, out_valid, out_tag, out_quad
  );

  modport slave (
    input  in_valid, in_angle, in_tag, out_ready,
    output in_ready, out_valid, out_tag, out_quad
  );
endinterface

// File: rtl/cordic_pipe_ctrl_valid_pipe.sv
// Shift register of slot records that shadows the datapath stages.
// Slot 0 sits beside z_reg; slot STAGES is the final stage seen at the output.
module cordic_valid_pipe
  import cordic_ctrl_pkg::*;
#(
  parameter int STAGES = STAGES_DEF
) (
  input  logic            C,
  input  logic            RST_N,
  input  logic            en,
  input  logic            clr,
  input  logic            push,
  input  logic [TAGW-1:0] push_tag,
  input  logic [1:0]      push_quad,
  output slot_t           out_slot
);

  slot_t [STAGES:0] slots_q;
  slot_t [STAGES:0] slots_d;

  // Next slot contents: clear drops valid bits only, enable shifts and loads slot 0.
  always_comb begin
    slots_d = slots_q;
    if (clr) begin
      for (int i = 0; i <= STAGES; i++) slots_d[i].valid = 1'b0;
    end else if (en) begin
      for (int i = STAGES; i > 0; i--) slots_d[i] = slots_q[i-1];
      slots_d[0].valid = push;
      if (push) begin
        slots_d[0].tag  = push_tag;
        slots_d[0].quad = push_quad;
      end
    end
  end

  // Slot state registers.
  always_ff @(posedge C or negedge RST_N) begin
    if (!RST_N) slots_q <= '0;
    else        slots_q <= slots_d;
  end

  assign out_slot = slots_q[STAGES];

endmodule

// File: rtl/cordic_pipe_ctrl.sv
// Sequencing controller for the pipelined CORDIC rotator: handshake, global
// clock enable, stage-0 angle register and in-flight accounting.
module cordic_pipe_ctrl
  import cordic_ctrl_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int CNTW   = CNTW_DEF
) (
  input  logic                C,
  input  logic                RST_N,
  cordic_pipe_ctrl_if.slave   bus,
  input  logic                flush,
  output logic                CE,
  output logic [31:0]         z_reg,
  output logic                Z_31,
  output logic                Z_30,
  output logic [CNTW-1:0]     inflight,
  output logic                busy
);

  logic            accept;
  logic            deliver;
  logic [31:0]     z_reg_q, z_reg_d;
  logic [CNTW-1:0] inflight_q, inflight_d;
  slot_t           out_slot;

  // Whole pipe stalls only when a valid result is refused; reset holds CE low.
  always_comb begin
    CE           = RST_N & ~(bus.out_valid & ~bus.out_ready);
    bus.in_ready = CE & ~flush;
    accept       = bus.in_valid & bus.in_ready;
    deliver      = bus.out_valid & bus.out_ready;
  end

  // Stage-0 Z operand and in-flight count; flush empties the count but keeps z_reg.
  always_comb begin
    z_reg_d    = accept ? bus.in_angle : z_reg_q;
    inflight_d = inflight_q;
    if (flush)                   inflight_d = '0;
    else if (accept && !deliver) inflight_d = inflight_q + CNTW'(1);
    else if (!accept && deliver) inflight_d = inflight_q - CNTW'(1);
  end

  // Controller registers.
  always_ff @(posedge C or negedge RST_N) begin
    if (!RST_N) begin
      z_reg_q    <= '0;
      inflight_q <= '0;
    end else begin
      z_reg_q    <= z_reg_d;
      inflight_q <= inflight_d;
    end
  end

  cordic_valid_pipe #(.STAGES(STAGES)) u_valid_pipe (
    .C        (C),
    .RST_N    (RST_N),
    .en       (CE),
    .clr      (flush),
    .push     (accept),
    .push_tag (bus.in_tag),
    .push_quad(bus.in_angle[31:30]),
    .out_slot (out_slot)
  );

  assign bus.out_valid = out_slot.valid;
  assign bus.out_tag   = out_slot.tag;
  assign bus.out_quad  = out_slot.quad;
  assign z_reg         = z_reg_q;
  assign Z_31          = z_reg_q[31];
  assign Z_30          = z_reg_q[30];
  assign inflight      = inflight_q;
  assign busy          = (inflight_q != '0);

endmodule
